// File: rtl/sub_bytes_fwd.sv
// AES forward SubBytes over a 128-bit state. LANES S-box instances are reused
// over 16/LANES beats, sequenced by an IDLE/BUSY/DONE controller with valid/ready.

module sub_bytes_fwd_sbox (
    input  logic [7:0] x_i,
    output logic [7:0] y_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y_o = SBOX[x_i];
endmodule

module sub_bytes_fwd #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    localparam int BEATS = 16 / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_fwd: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [127:0]     work_q, work_d;

    logic [7:0]       wbyte    [16];
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];
    logic [127:0]     sub_word;

    // Beat k owns state bytes k*LANES .. k*LANES+LANES-1; lane l handles the l-th of them.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = wbyte[4'(int'(beat_q) * LANES + l)];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sub_bytes_fwd_sbox u_sbox (
            .x_i (lane_in[l]),
            .y_o (lane_out[l])
        );
    end

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign wbyte[i] = work_q[127-8*i -: 8];
        assign sub_word[127-8*i -: 8] = (int'(beat_q) == i / LANES) ? lane_out[i % LANES] : wbyte[i];
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = sub_word;
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = work_q;
endmodule

// File: tb/tb_sub_bytes_fwd.sv
// Scoreboard bench for sub_bytes_fwd with LANES = 1, 4 and 16 side by side;
// expected states come from a GF(2^8) inverse + affine reference model.

module tb_sub_bytes_fwd;
    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];

    typedef struct {
        int           dut;
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t       sb_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         acc_cnt   [3] = '{0, 0, 0};
    int         prev_acc  [3] = '{-1, -1, -1};
    int         first_cyc [3] = '{0, 0, 0};
    bit         vld_prev  [3] = '{1'b0, 1'b0, 1'b0};
    bit         b2b_mode = 1'b0;
    logic [7:0] sbox_ref [256];
    logic [7:0] inv_ref  [256];
    logic [7:0] spot_x [4] = '{8'h00, 8'h01, 8'h53, 8'hff};
    logic [7:0] spot_y [4] = '{8'h63, 8'h7c, 8'hed, 8'h16};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_bytes_fwd #(.LANES(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int nbeats(input int g);
        return (g == 0) ? 16 : ((g == 1) ? 4 : 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S(x) = affine(x^-1) in GF(2^8) mod x^8+x^4+x^3+x+1; inverse table by inverting S.
    task automatic build_ref();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_ref[a] = s;
            inv_ref[s]  = 8'(a);
        end
    endtask

    function automatic logic [127:0] sub_block(input logic [127:0] d);
        logic [127:0] r, t;
        r = '0; t = d;
        for (int i = 0; i < 16; i++) begin
            r = {r[119:0], sbox_ref[t[127:120]]};
            t = t << 8;
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: records accepts into the scoreboard, pops and compares on output handshakes.
    initial begin
        int idx;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                for (int g = 0; g < 3; g++) vld_prev[g] = 1'b0;
            end else begin
                for (int g = 0; g < 3; g++) begin
                    if (out_valid[g] && !vld_prev[g]) first_cyc[g] = cyc;
                    vld_prev[g] = out_valid[g];
                    if (out_valid[g]) chk(!in_ready[g], "in_ready_low_in_done", in_ready[g], 0);
                    if (out_valid[g] && out_ready[g]) begin
                        idx = -1;
                        for (int k = 0; k < sb_q.size(); k++) begin
                            if (sb_q[k].dut == g) begin
                                idx = k;
                                break;
                            end
                        end
                        chk(idx >= 0, "unexpected_output", out_data[g], 0);
                        if (idx >= 0) begin
                            chk(out_data[g] == sb_q[idx].data, "out_data", out_data[g], sb_q[idx].data);
                            chk(first_cyc[g] - sb_q[idx].acc == nbeats(g), "latency",
                                first_cyc[g] - sb_q[idx].acc, nbeats(g));
                            sb_q.delete(idx);
                        end
                        vld_prev[g] = 1'b0;
                    end
                    if (in_valid[g] && in_ready[g]) begin
                        if (b2b_mode && prev_acc[g] >= 0)
                            chk(cyc + 1 - prev_acc[g] == nbeats(g) + 2, "b2b_period",
                                cyc + 1 - prev_acc[g], nbeats(g) + 2);
                        prev_acc[g] = cyc + 1;
                        e.dut  = g;
                        e.data = sub_block(in_data[g]);
                        e.acc  = cyc + 1;
                        sb_q.push_back(e);
                        acc_cnt[g]++;
                    end
                end
            end
        end
    end

    // Presents one block to the LANES=4 instance; returns at the first negedge with out_valid.
    task automatic send1(input logic [127:0] d, output logic [127:0] got, output int lat);
        in_valid[1] = 1'b1;
        in_data[1]  = d;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        got = '0;
        lat = -1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid[1]) begin
                lat = k;
                got = out_data[1];
                break;
            end
        end
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 300 && sb_q.size() != 0; c++) @(negedge clk);
        chk(sb_q.size() == 0, nm, sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic stream(input bit b2b, input int nblk);
        int last [3];
        int base [3];
        bit done;
        b2b_mode = b2b;
        done = 1'b0;
        for (int g = 0; g < 3; g++) begin
            prev_acc[g]  = -1;
            base[g]      = acc_cnt[g];
            last[g]      = acc_cnt[g];
            in_valid[g]  = b2b ? 1'b1 : 1'($urandom_range(0, 1));
            in_data[g]   = rand128();
            out_ready[g] = 1'b1;
        end
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            done = 1'b1;
            for (int g = 0; g < 3; g++) begin
                if (acc_cnt[g] - base[g] >= nblk) begin
                    in_valid[g] = 1'b0;
                end else begin
                    done = 1'b0;
                    if (b2b) begin
                        if (acc_cnt[g] != last[g]) in_data[g] = rand128();
                        in_valid[g] = 1'b1;
                    end else begin
                        in_valid[g] = 1'($urandom_range(0, 1));
                        in_data[g]  = rand128();
                    end
                end
                last[g]      = acc_cnt[g];
                out_ready[g] = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            if (done) break;
        end
        chk(done, b2b ? "b2b_stream_timeout" : "rand_stream_timeout", done, 1);
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b1;
        end
        drain(b2b ? "b2b_drain" : "rand_drain");
        b2b_mode = 1'b0;
    endtask

    initial begin
        logic [127:0] got, d, tmp;
        logic [127:0] fips_in, fips_out;
        logic [7:0]   x, y;
        int           lat, seen;

        fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        fips_out = 128'hd42711aee0bf98f1b8b45de51e415230;
        build_ref();
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            in_data[g]   = '0;
            out_ready[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk(in_ready[g] == 1'b1, "reset_in_ready", in_ready[g], 1);
            chk(out_valid[g] == 1'b0, "reset_out_valid", out_valid[g], 0);
            chk(out_data[g] == '0, "reset_out_data", out_data[g], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 appendix vector
        out_ready[1] = 1'b1;
        send1(fips_in, got, lat);
        chk(got == fips_out, "fips_data", got, fips_out);
        chk(lat == 4, "fips_latency", lat, 4);
        @(negedge clk);
        chk(out_valid[1] == 1'b0, "fips_valid_one_cycle", out_valid[1], 0);
        @(posedge clk); #1;

        // All 256 byte values, 16 per block
        for (int b = 0; b < 16; b++) begin
            d = '0;
            for (int i = 0; i < 16; i++) d = {d[119:0], 8'(16 * b + i)};
            send1(d, got, lat);
            chk(lat == 4, "sweep_latency", lat, 4);
            tmp = got;
            for (int i = 0; i < 16; i++) begin
                x = 8'(16 * b + i);
                y = tmp[127:120];
                tmp = tmp << 8;
                chk(inv_ref[y] == x, "sweep_inverse", inv_ref[y], x);
                for (int j = 0; j < 4; j++) begin
                    if (x == spot_x[j]) chk(y == spot_y[j], "sweep_spot", y, spot_y[j]);
                end
            end
            @(posedge clk); #1;
        end
        drain("sweep_drain");

        // Output back-pressure, then release with a new input already waiting
        out_ready[1] = 1'b0;
        d = rand128();
        send1(d, got, lat);
        chk(lat == 4, "stall_latency", lat, 4);
        chk(got == sub_block(d), "stall_first_data", got, sub_block(d));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid[1] = 1'b1;
            in_data[1]  = rand128();
            @(negedge clk);
            chk(out_valid[1] == 1'b1, "stall_out_valid", out_valid[1], 1);
            chk(out_data[1] == got, "stall_out_data", out_data[1], got);
            chk(in_ready[1] == 1'b0, "stall_in_ready", in_ready[1], 0);
        end
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk(in_ready[1] == 1'b1, "release_in_ready", in_ready[1], 1);
        chk(out_valid[1] == 1'b0, "release_out_valid", out_valid[1], 0);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        drain("release_drain");

        // Reset during the second BUSY cycle
        in_valid[1] = 1'b1;
        in_data[1]  = rand128();
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(negedge clk);
        chk(in_ready[1] == 1'b0, "rst_busy_in_ready", in_ready[1], 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(in_ready[1] == 1'b1, "rst_mid_in_ready", in_ready[1], 1);
        chk(out_valid[1] == 1'b0, "rst_mid_out_valid", out_valid[1], 0);
        chk(out_data[1] == '0, "rst_mid_out_data", out_data[1], 0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid[1]) seen++;
        end
        chk(seen == 0, "rst_block_discarded", seen, 0);
        @(posedge clk); #1;

        stream(1'b1, 6);
        stream(1'b0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
